// File: rtl/flag_scan_controller.sv
// ============================================================================
// Module   : flag_scan_controller
// Purpose  : Handshaked iterator over a latched flag vector, LSB to MSB.
// Revision : 1.0
// ============================================================================
`default_nettype none

module flag_scan_controller #(
    parameter int WIDTH = 16,
    parameter int IDX_W = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] flag_in,
    input  logic             resume,
    input  logic             stop,
    input  logic             abort,
    output logic             busy,
    output logic             hit,
    output logic             done,
    output logic             found,
    output logic [IDX_W-1:0] index,
    output logic [IDX_W:0]   hit_count
);

    localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_HIT  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             r_state,  w_state_nxt;
    logic [WIDTH-1:0]   r_shadow, w_shadow_nxt;
    logic [IDX_W-1:0]   r_ptr,    w_ptr_nxt;
    logic               r_found,  w_found_nxt;
    logic [IDX_W-1:0]   r_index,  w_index_nxt;
    logic [IDX_W:0]     r_count,  w_count_nxt;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_shadow <= '0;
            r_ptr    <= '0;
            r_found  <= 1'b0;
            r_index  <= '0;
            r_count  <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_shadow <= w_shadow_nxt;
            r_ptr    <= w_ptr_nxt;
            r_found  <= w_found_nxt;
            r_index  <= w_index_nxt;
            r_count  <= w_count_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_shadow_nxt = r_shadow;
        w_ptr_nxt    = r_ptr;
        w_found_nxt  = r_found;
        w_index_nxt  = r_index;
        w_count_nxt  = r_count;

        // Abort leaves the result registers untouched so software can inspect them.
        if (abort && (r_state != S_IDLE)) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        w_shadow_nxt = flag_in;
                        w_ptr_nxt    = '0;
                        w_found_nxt  = 1'b0;
                        w_index_nxt  = '0;
                        w_count_nxt  = '0;
                        w_state_nxt  = S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (r_shadow[r_ptr]) begin
                        w_index_nxt = r_ptr;
                        w_found_nxt = 1'b1;
                        w_count_nxt = r_count + (IDX_W+1)'(1);
                        w_state_nxt = S_HIT;
                    end else if (r_ptr == c_last_idx) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_ptr_nxt = r_ptr + IDX_W'(1);
                    end
                end
                S_HIT: begin
                    if (stop) begin
                        w_state_nxt = S_DONE;
                    end else if (resume && (r_ptr == c_last_idx)) begin
                        w_state_nxt = S_DONE;
                    end else if (resume) begin
                        w_ptr_nxt   = r_ptr + IDX_W'(1);
                        w_state_nxt = S_SCAN;
                    end
                end
                S_DONE: begin
                    w_state_nxt = S_IDLE;
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    assign busy      = (r_state == S_SCAN) || (r_state == S_HIT);
    assign hit       = (r_state == S_HIT);
    assign done      = (r_state == S_DONE);
    assign found     = r_found;
    assign index     = r_index;
    assign hit_count = r_count;

endmodule

`default_nettype wire

// File: tb/tb_flag_scan_controller.sv
// ============================================================================
// Module   : tb_flag_scan_controller
// Purpose  : Randomized scan transactions checked against a set-bit-list model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_flag_scan_controller;

    localparam int WIDTH = 16;
    localparam int IDX_W = 4;

    logic             clock = 1'b0;
    logic             reset;
    logic             start;
    logic [WIDTH-1:0] flag_in;
    logic             resume;
    logic             stop;
    logic             abort;
    logic             busy;
    logic             hit;
    logic             done;
    logic             found;
    logic [IDX_W-1:0] index;
    logic [IDX_W:0]   hit_count;

    int n_vec = 0;
    int n_err = 0;

    // Expected results of the current/last scan
    int m_found = 0;
    int m_index = 0;
    int m_count = 0;

    flag_scan_controller #(.WIDTH(WIDTH), .IDX_W(IDX_W)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .flag_in   (flag_in),
        .resume    (resume),
        .stop      (stop),
        .abort     (abort),
        .busy      (busy),
        .hit       (hit),
        .done      (done),
        .found     (found),
        .index     (index),
        .hit_count (hit_count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_results(input string tag);
        chk({tag, "_found"}, {31'd0, found}, m_found);
        chk({tag, "_index"}, {28'd0, index}, m_index);
        chk({tag, "_count"}, {27'd0, hit_count}, m_count);
    endtask

    task automatic do_abort();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy", {31'd0, busy}, 0);
        chk("abort_hit",  {31'd0, hit},  0);
        chk("abort_done", {31'd0, done}, 0);
        chk_results("abort");
        tick();
        chk("abort_idle_done", {31'd0, done}, 0);
        chk("abort_idle_busy", {31'd0, busy}, 0);
    endtask

    // policy: 0 random, 1 stop on first hit, 2 resume always, 3 stop+resume on first hit
    task automatic run_scan(input logic [WIDTH-1:0] f, input int policy, input int abort_at);
        int  prev;
        int  ecount;
        int  holds;
        int  gap;
        int  tail;
        bit  stop_now;
        ecount  = 0;
        flag_in = f;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        flag_in = WIDTH'($urandom);
        m_found = 0;
        m_index = 0;
        m_count = 0;
        chk("start_busy", {31'd0, busy}, 1);
        chk("start_hit",  {31'd0, hit},  0);
        chk_results("start");
        prev = -1;
        for (int b = 0; b < WIDTH; b++) begin
            if (f[b]) begin
                gap = b - prev;
                for (int d = 1; d <= gap; d++) begin
                    if (abort_at == ecount) begin
                        do_abort();
                        return;
                    end
                    start = ($urandom_range(3) == 0);
                    tick();
                    ecount++;
                    start = 1'b0;
                    chk("wait_hit",  {31'd0, hit},  (d == gap) ? 1 : 0);
                    chk("wait_busy", {31'd0, busy}, 1);
                    chk("wait_done", {31'd0, done}, 0);
                end
                m_found = 1;
                m_index = b;
                m_count++;
                chk_results("hit");
                holds = (policy == 0) ? $urandom_range(2) : 0;
                for (int h = 0; h < holds; h++) begin
                    if (abort_at == ecount) begin
                        do_abort();
                        return;
                    end
                    start = ($urandom_range(1) == 0);
                    tick();
                    ecount++;
                    start = 1'b0;
                    chk("hold_hit", {31'd0, hit}, 1);
                    chk_results("hold");
                end
                stop_now = (policy == 1) || (policy == 3) ||
                           ((policy == 0) && ($urandom_range(3) == 0));
                if (stop_now) begin
                    stop   = 1'b1;
                    resume = (policy == 3) ? 1'b1 : ((policy == 0) ? 1'($urandom_range(1)) : 1'b0);
                    tick();
                    stop   = 1'b0;
                    resume = 1'b0;
                    chk("stop_done", {31'd0, done}, 1);
                    chk("stop_busy", {31'd0, busy}, 0);
                    chk("stop_hit",  {31'd0, hit},  0);
                    chk_results("stop");
                    tick();
                    chk("stop_idle_done", {31'd0, done}, 0);
                    chk_results("stop_idle");
                    return;
                end
                resume = 1'b1;
                tick();
                ecount++;
                resume = 1'b0;
                prev   = b;
                if (b == WIDTH - 1) begin
                    chk("last_done", {31'd0, done}, 1);
                    chk("last_busy", {31'd0, busy}, 0);
                    tick();
                    chk("last_idle_done", {31'd0, done}, 0);
                    chk_results("last");
                    return;
                end
                chk("resume_hit",  {31'd0, hit},  0);
                chk("resume_busy", {31'd0, busy}, 1);
            end
        end
        tail = WIDTH - 1 - prev;
        for (int d = 1; d <= tail; d++) begin
            if (abort_at == ecount) begin
                do_abort();
                return;
            end
            tick();
            ecount++;
            chk("tail_done", {31'd0, done}, (d == tail) ? 1 : 0);
            chk("tail_hit",  {31'd0, hit},  0);
            chk("tail_busy", {31'd0, busy}, (d == tail) ? 0 : 1);
        end
        tick();
        chk("end_done", {31'd0, done}, 0);
        chk("end_busy", {31'd0, busy}, 0);
        chk_results("end");
    endtask

    initial begin
        reset   = 1'b1;
        start   = 1'b1;
        flag_in = 16'hFFFF;
        resume  = 1'b0;
        stop    = 1'b0;
        abort   = 1'b0;
        tick();
        tick();
        start   = 1'b0;
        reset   = 1'b0;
        chk("rst_busy",  {31'd0, busy},  0);
        chk("rst_hit",   {31'd0, hit},   0);
        chk("rst_done",  {31'd0, done},  0);
        chk_results("rst");

        // Directed cases
        run_scan(16'h2000, 1, -1);
        run_scan(16'h0000, 2, -1);
        run_scan(16'h8001, 2, -1);
        run_scan(16'h0010, 1, -1);
        run_scan(16'h4000, 2, 5);
        run_scan(16'h4000, 2, -1);
        run_scan(16'h0240, 3, -1);
        run_scan(16'hFFFF, 2, -1);

        // Abort in IDLE has no visible effect
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("idle_abort_busy", {31'd0, busy}, 0);
        chk_results("idle_abort");

        // Randomized transactions
        for (int t = 0; t < 60; t++) begin
            logic [WIDTH-1:0] f;
            int               ab;
            f = WIDTH'($urandom);
            if ($urandom_range(2) == 0) f = f & WIDTH'($urandom);
            ab = ($urandom_range(3) == 0) ? int'($urandom_range(20)) : -1;
            run_scan(f, 0, ab);
        end

        // Reset while holding in HIT
        flag_in = 16'h0100;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        repeat (9) tick();
        chk("pre_reset_hit", {31'd0, hit}, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m_found = 0;
        m_index = 0;
        m_count = 0;
        chk("reset_hit",  {31'd0, hit},  0);
        chk("reset_busy", {31'd0, busy}, 0);
        chk("reset_done", {31'd0, done}, 0);
        chk_results("reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
